sent_rx_line_conditioner: RTL and testbench

//  Front end of the SENT receiver, directly upstream of the pulse decoder on sent_rx_i.
//  - Synchronises the raw SENT pin into clk_rx and rejects short glitches.
//  - Detects falling edges on the cleaned line and timestamps the interval between

---
 rtl/sent_rx_pkg.sv | 22 ++
 rtl/sent_rx_glitch_filter.sv | 92 +++++++++
 rtl/sent_rx_line_conditioner.sv | 113 +++++++++++
 tb/tb_sent_rx_line_conditioner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_rx_pkg.sv
// Shared constants and types for the SENT receiver line conditioner.
package sent_rx_pkg;

    // Level of an idle SENT line.
    localparam logic SENT_IDLE_LEVEL = 1'b1;

    // Interval FSM state encoding.
    localparam logic STATE_IDLE    = 1'b0;
    localparam logic STATE_MEASURE = 1'b1;

    typedef enum logic {
        IDLE    = STATE_IDLE,
        MEASURE = STATE_MEASURE
    } rx_state_e;

    // Default parameter values.
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILTER_LEN  = 3;
    localparam int DEF_CNT_WIDTH   = 12;
    localparam int DEF_GLITCH_W    = 8;

endpackage

// File: rtl/sent_rx_glitch_filter.sv
// Synchroniser, run-length glitch filter and saturating glitch counter for
// the raw SENT line. The filtered level only changes after FILTER_LEN
// consecutive synchronised samples disagree with it.
module sent_rx_glitch_filter
    import sent_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int GLITCH_W    = DEF_GLITCH_W
) (
    input  logic                clk_rx,
    input  logic                reset_rx,
    input  logic                sent_rx_i,
    input  logic                clear_i,
    output logic                sent_filt_o,
    output logic                filt_fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int RUN_W = $clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic [RUN_W-1:0]       run_reg;
    logic [RUN_W-1:0]       run_next;
    logic                   filt_reg;
    logic                   filt_next;
    logic [GLITCH_W-1:0]    glitch_reg;
    logic [GLITCH_W-1:0]    glitch_next;

    logic synced;
    logic differ;
    logic accept;
    logic glitch;

    // Plain flop chain: stage 0 samples the pin, each later stage copies the one before.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = sent_rx_i;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign synced = sync_reg[SYNC_STAGES-1];
    assign differ = synced != filt_reg;
    assign accept = differ && (run_reg == RUN_LAST);
    // A disagreement run that ends without being accepted is a glitch.
    assign glitch = !differ && (run_reg != '0);

    // Next-state for run length, filtered level and glitch count.
    always_comb begin
        run_next    = '0;
        filt_next   = filt_reg;
        glitch_next = glitch_reg;
        if (accept) begin
            filt_next = synced;
        end else if (differ) begin
            run_next = run_reg + RUN_W'(1);
        end
        if (clear_i) begin
            glitch_next = '0;
        end else if (glitch && (glitch_reg != GLITCH_MAX)) begin
            glitch_next = glitch_reg + GLITCH_W'(1);
        end
    end

    // Register all filter state; the line idles high out of reset.
    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            sync_reg   <= {SYNC_STAGES{SENT_IDLE_LEVEL}};
            run_reg    <= '0;
            filt_reg   <= SENT_IDLE_LEVEL;
            glitch_reg <= '0;
        end else begin
            sync_reg   <= sync_next;
            run_reg    <= run_next;
            filt_reg   <= filt_next;
            glitch_reg <= glitch_next;
        end
    end

    assign sent_filt_o  = filt_reg;
    // High in the cycle before the filtered line first reads low.
    assign filt_fall_o  = accept && !synced;
    assign glitch_cnt_o = glitch_reg;

endmodule

// File: rtl/sent_rx_line_conditioner.sv
// SENT receiver front end: cleaned line, falling-edge pulse and the
// clk_rx-cycle interval between consecutive falling edges.
module sent_rx_line_conditioner
    import sent_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int GLITCH_W    = DEF_GLITCH_W
) (
    input  logic                 clk_rx,
    input  logic                 reset_rx,
    input  logic                 sent_rx_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    output logic                 sent_filt_o,
    output logic                 fall_edge_o,
    output logic [CNT_WIDTH-1:0] interval_o,
    output logic                 interval_valid_o,
    output logic                 overflow_o,
    output logic [GLITCH_W-1:0]  glitch_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 filt_fall;
    logic                 fall_edge_reg;
    logic                 fall_edge_next;
    rx_state_e            state_reg;
    rx_state_e            state_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] interval_reg;
    logic [CNT_WIDTH-1:0] interval_next;
    logic                 overflow_reg;
    logic                 overflow_next;
    logic                 valid_reg;
    logic                 valid_next;

    sent_rx_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .GLITCH_W    (GLITCH_W)
    ) u_filter (
        .clk_rx       (clk_rx),
        .reset_rx     (reset_rx),
        .sent_rx_i    (sent_rx_i),
        .clear_i      (clear_i),
        .sent_filt_o  (sent_filt_o),
        .filt_fall_o  (filt_fall),
        .glitch_cnt_o (glitch_cnt_o)
    );

    assign fall_edge_next = filt_fall && enable_i;

    // Interval FSM: first edge starts counting, later edges report and restart.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        interval_next = interval_reg;
        overflow_next = overflow_reg;
        valid_next    = 1'b0;
        if (!enable_i) begin
            // Disable wins over a coincident edge; reported values are held.
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fall_edge_reg) begin
                        state_next = MEASURE;
                        cnt_next   = CNT_WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (fall_edge_reg) begin
                        interval_next = cnt_reg;
                        overflow_next = (cnt_reg == CNT_MAX);
                        valid_next    = 1'b1;
                        cnt_next      = CNT_WIDTH'(1);
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            fall_edge_reg <= 1'b0;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            interval_reg  <= '0;
            overflow_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            fall_edge_reg <= fall_edge_next;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            interval_reg  <= interval_next;
            overflow_reg  <= overflow_next;
            valid_reg     <= valid_next;
        end
    end

    assign fall_edge_o      = fall_edge_reg;
    assign interval_o       = interval_reg;
    assign interval_valid_o = valid_reg;
    assign overflow_o       = overflow_reg;

endmodule

// File: tb/tb_sent_rx_line_conditioner.sv
// Bench for sent_rx_line_conditioner: directed scenarios plus random line
// activity, checked every cycle against a behavioural model.
module tb_sent_rx_line_conditioner;

    localparam int S    = 2;
    localparam int F    = 3;
    localparam int CW   = 12;
    localparam int GW   = 8;
    localparam int CMAX = (1 << CW) - 1;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk_rx    = 1'b0;
    logic          reset_rx  = 1'b0;
    logic          sent_rx_i = 1'b1;
    logic          enable_i  = 1'b1;
    logic          clear_i   = 1'b0;
    logic          sent_filt_o;
    logic          fall_edge_o;
    logic [CW-1:0] interval_o;
    logic          interval_valid_o;
    logic          overflow_o;
    logic [GW-1:0] glitch_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_rx = ~clk_rx;

    sent_rx_line_conditioner dut (
        .clk_rx           (clk_rx),
        .reset_rx         (reset_rx),
        .sent_rx_i        (sent_rx_i),
        .enable_i         (enable_i),
        .clear_i          (clear_i),
        .sent_filt_o      (sent_filt_o),
        .fall_edge_o      (fall_edge_o),
        .interval_o       (interval_o),
        .interval_valid_o (interval_valid_o),
        .overflow_o       (overflow_o),
        .glitch_cnt_o     (glitch_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input longint exp);
        total++;
        if (act !== 64'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_q[$];       // raw samples still travelling through the synchroniser
    int     m_hist[$];    // last F synchronised samples seen by the filter
    int     m_prev_s, m_filt, m_fall, m_glitch;
    int     m_measuring, m_interval, m_ovf, m_valid;
    int     m_fall_count, m_coincident;
    longint m_edge = 0;
    longint m_fall_at, m_fe_edge;
    int     m_str_int[$];
    int     m_str_ovf[$];

    always @(posedge clk_rx or posedge reset_rx) begin
        if (reset_rx) begin
            m_q = {};
            m_hist = {};
            for (int i = 0; i < S; i++) m_q.push_back(1);
            for (int i = 0; i < F; i++) m_hist.push_back(1);
            m_prev_s = 1; m_filt = 1; m_fall = 0; m_glitch = 0;
            m_measuring = 0; m_interval = 0; m_ovf = 0; m_valid = 0;
            m_fall_count = 0; m_fall_at = 0; m_fe_edge = 0;
        end else begin
            int     s, glitch, flip;
            longint d;
            m_edge++;
            s = m_q[0];
            void'(m_q.pop_front());
            m_q.push_back(int'(sent_rx_i));
            // Interval: time between the cycles in which edge pulses were visible.
            m_valid = 0;
            if (!enable_i) begin
                m_measuring = 0;
            end else if (m_fall != 0) begin
                if (m_measuring != 0) begin
                    d = m_fall_at - m_fe_edge;
                    m_interval = (d >= CMAX) ? CMAX : int'(d);
                    m_ovf = (d >= CMAX) ? 1 : 0;
                    m_valid = 1;
                    m_str_int.push_back(m_interval);
                    m_str_ovf.push_back(m_ovf);
                end
                m_measuring = 1;
                m_fe_edge = m_fall_at;
            end
            // Filter: flip once F consecutive samples disagree; a shorter
            // disagreement ending in agreement is a glitch.
            m_hist.push_back(s);
            void'(m_hist.pop_front());
            glitch = (s == m_filt && m_prev_s != m_filt) ? 1 : 0;
            flip = 1;
            foreach (m_hist[k]) if (m_hist[k] == m_filt) flip = 0;
            if (clear_i) begin
                if (glitch != 0) m_coincident++;
                m_glitch = 0;
            end else if (glitch != 0 && m_glitch < GMAX) begin
                m_glitch++;
            end
            m_fall = 0;
            if (flip != 0) begin
                m_filt = s;
                if (s == 0 && enable_i) begin
                    m_fall = 1;
                    m_fall_at = m_edge;
                    m_fall_count++;
                end
            end
            m_prev_s = s;
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk_rx);
            #1;
            chk("filt", sent_filt_o, m_filt);
            chk("fall_edge", fall_edge_o, m_fall);
            chk("valid", interval_valid_o, m_valid);
            chk("interval", interval_o, m_interval);
            chk("overflow", overflow_o, m_ovf);
            chk("glitch_cnt", glitch_cnt_o, m_glitch);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_rx);
    endtask

    task automatic pulse(input int low_len, input int high_len);
        sent_rx_i = 1'b0;
        tick(low_len);
        sent_rx_i = 1'b1;
        tick(high_len);
    endtask

    task automatic do_reset();
        @(negedge clk_rx);
        sent_rx_i = 1'b1;
        enable_i  = 1'b1;
        clear_i   = 1'b0;
        reset_rx  = 1'b1;
        tick(2);
        reset_rx = 1'b0;
        tick(6);
        m_str_int = {};
        m_str_ovf = {};
    endtask

    task automatic chk_strobe(input string name, input int idx, input int iv, input int ov);
        if (m_str_int.size() > idx) begin
            chk({name, "_interval"}, m_str_int[idx], iv);
            chk({name, "_overflow"}, m_str_ovf[idx], ov);
        end else begin
            chk({name, "_missing"}, m_str_int.size(), idx + 1);
        end
    endtask

    initial begin
        int lat;
        // Test 1: reset with the line held low.
        sent_rx_i = 1'b0;
        reset_rx  = 1'b1;
        tick(2);
        #2;
        chk("t1_rst_filt", sent_filt_o, 1);
        chk("t1_rst_fall", fall_edge_o, 0);
        chk("t1_rst_valid", interval_valid_o, 0);
        chk("t1_rst_interval", interval_o, 0);
        chk("t1_rst_overflow", overflow_o, 0);
        chk("t1_rst_glitch", glitch_cnt_o, 0);
        @(negedge clk_rx);
        reset_rx = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk_rx);
            #1;
            if (m_filt == 0) begin
                lat = n;
                break;
            end
        end
        chk("t1_latency", lat, 5);
        chk("t1_fall_with_filt", m_fall, 1);
        tick(4);

        // Test 2: edges 56 then 12 apart.
        do_reset();
        pulse(10, 46);
        pulse(6, 6);
        pulse(10, 60);
        chk("t2_strobes", m_str_int.size(), 2);
        chk_strobe("t2_a", 0, 56, 0);
        chk_strobe("t2_b", 1, 12, 0);

        // Test 3: 2-cycle glitch rejected, 3-cycle pulse accepted.
        do_reset();
        pulse(2, 30);
        chk("t3_glitch", m_glitch, 1);
        chk("t3_no_fall", m_fall_count, 0);
        chk("t3_filt_high", m_filt, 1);
        pulse(3, 30);
        chk("t3_fall", m_fall_count, 1);

        // Test 4: saturation then a normal interval.
        do_reset();
        pulse(10, 4990);
        pulse(10, 46);
        pulse(10, 46);
        chk("t4_strobes", m_str_int.size(), 2);
        chk_strobe("t4_sat", 0, CMAX, 1);
        chk_strobe("t4_after", 1, 56, 0);

        // Test 5: enable dropped mid-measurement.
        do_reset();
        pulse(10, 46);
        pulse(10, 20);
        enable_i = 1'b0;
        pulse(10, 10);
        enable_i = 1'b1;
        tick(10);
        pulse(10, 46);
        pulse(10, 46);
        chk("t5_strobes", m_str_int.size(), 2);
        chk_strobe("t5_before", 0, 56, 0);
        chk_strobe("t5_after", 1, 56, 0);

        // Test 6: reset mid-measurement, glitch saturation, clear priority.
        do_reset();
        pulse(10, 46);
        pulse(10, 20);
        chk("t6_pre_interval", m_interval, 56);
        sent_rx_i = 1'b0;
        reset_rx  = 1'b1;
        #1;
        chk("t6_rst_interval", interval_o, 0);
        chk("t6_rst_filt", sent_filt_o, 1);
        chk("t6_rst_valid", interval_valid_o, 0);
        chk("t6_rst_fall", fall_edge_o, 0);
        tick(2);
        sent_rx_i = 1'b1;
        reset_rx  = 1'b0;
        tick(6);
        repeat (GMAX + 2) pulse(2, 4);
        tick(4);
        chk("t6_glitch_sat", m_glitch, GMAX);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        tick(2);
        chk("t6_clear", m_glitch, 0);
        pulse(2, 6);
        chk("t6_one_glitch", m_glitch, 1);
        sent_rx_i = 1'b0;
        tick(2);
        sent_rx_i = 1'b1;
        tick(2);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        tick(4);
        chk("t6_coincident_seen", m_coincident, 1);
        chk("t6_clear_wins", m_glitch, 0);

        // Random line activity with enable toggles and clears.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int l, h;
            l = $urandom_range(1, 8);
            h = $urandom_range(1, 70);
            if ($urandom_range(0, 7) == 0) enable_i = ~enable_i;
            if (i == 200) do_reset();
            clear_i   = ($urandom_range(0, 11) == 0);
            sent_rx_i = 1'b0;
            tick(1);
            clear_i = 1'b0;
            if (l > 1) tick(l - 1);
            sent_rx_i = 1'b1;
            tick(h);
        end
        enable_i = 1'b1;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
